// File: rtl/lock_request_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lock_request_arbiter_pkg
//   Shared definitions for the lock request arbiter and its per-thread FSMs:
//   lock ID width, deny counter width, backoff counter width, the per-thread
//   state enum and a saturating-increment helper.
// -----------------------------------------------------------------------------
package lock_request_arbiter_pkg;

  localparam int LOCK_WIDTH = 4;
  localparam int DENY_CNT_W = 16;
  // Wide enough for the largest supported retry delay (255).
  localparam int BACKOFF_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_BACKOFF,
    ST_HOLD,
    ST_REL_PEND
  } thread_state_e;

  function automatic logic [DENY_CNT_W-1:0] sat_inc(input logic [DENY_CNT_W-1:0] v);
    return (&v) ? v : v + DENY_CNT_W'(1);
  endfunction

endpackage

// File: rtl/lock_request_arbiter_thread_fsm.sv
// -----------------------------------------------------------------------------
// lock_thread_fsm
//   One per thread. Tracks the acquire/release life cycle of a single lock for
//   that thread, stores the requested lock ID and runs the retry backoff.
//
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   acq_req      thread wants its lock (level)
//   acq_lock     requested lock ID, captured on leaving IDLE
//   rel_req      thread releases its held lock (pulse, honoured in HOLD only)
//   acq_sel      this thread won acquire arbitration this cycle
//   granted      table response to this cycle's request
//   rel_sel      this thread won release arbitration this cycle
//   pend         thread is waiting to issue an acquire
//   rel_pend     thread is waiting to issue a release
//   held         thread owns a lock (HOLD or REL_PEND)
//   acq_done     one-cycle pulse after a grant
//   held_id      captured lock ID
// -----------------------------------------------------------------------------
module lock_thread_fsm
  import lock_request_arbiter_pkg::*;
#(
  parameter int LOCK_W      = LOCK_WIDTH,
  parameter int RETRY_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_req,
  input  logic [LOCK_W-1:0] acq_lock,
  input  logic              rel_req,
  input  logic              acq_sel,
  input  logic              granted,
  input  logic              rel_sel,
  output logic              pend,
  output logic              rel_pend,
  output logic              held,
  output logic              acq_done,
  output logic [LOCK_W-1:0] held_id
);

  localparam logic [BACKOFF_W-1:0] RELOAD = BACKOFF_W'(RETRY_DELAY);

  thread_state_e        state;
  thread_state_e        state_next;
  logic [BACKOFF_W-1:0] backoff_cnt;
  logic                 win;
  logic                 lose;

  assign win  = (state == ST_PEND) && acq_sel && granted;
  assign lose = (state == ST_PEND) && acq_sel && !granted;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (acq_req) state_next = ST_PEND;
      // Once the table has granted, ownership is real even if the thread
      // dropped its request in the same cycle, so a grant beats a cancel.
      ST_PEND: begin
        if (win)           state_next = ST_HOLD;
        else if (!acq_req) state_next = ST_IDLE;
        else if (lose)     state_next = ST_BACKOFF;
      end
      ST_BACKOFF: begin
        if (!acq_req)                            state_next = ST_IDLE;
        else if (backoff_cnt <= BACKOFF_W'(1))   state_next = ST_PEND;
      end
      ST_HOLD:     if (rel_req) state_next = ST_REL_PEND;
      ST_REL_PEND: if (rel_sel) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    pend     = (state == ST_PEND);
    rel_pend = (state == ST_REL_PEND);
    held     = (state == ST_HOLD) || (state == ST_REL_PEND);
  end

  // Datapath: captured lock ID, backoff counter, done pulse.
  // NOTE: held_id is reset even though it is only read after capture, so
  // lock_requested/lock_released never carry X out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_id     <= '0;
      backoff_cnt <= '0;
      acq_done    <= 1'b0;
    end else begin
      acq_done <= win;
      if ((state == ST_IDLE) && acq_req) held_id <= acq_lock;
      // Counter holds RETRY_DELAY on BACKOFF entry and counts down; the
      // thread returns to PEND as it would reach zero, giving exactly
      // RETRY_DELAY cycles of backoff.
      if (state_next == ST_BACKOFF)
        backoff_cnt <= (state == ST_BACKOFF) ? backoff_cnt - BACKOFF_W'(1) : RELOAD;
      else
        backoff_cnt <= '0;
    end
  end

endmodule

// File: rtl/lock_request_arbiter.sv
// -----------------------------------------------------------------------------
// lock_request_arbiter
//   Front end for the lock availability table. Serializes per-thread acquire
//   requests (round-robin) and release requests (fixed priority, lowest index)
//   onto the table's single request and release ports, and counts denies.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   acq_req         per-thread acquire request (level)
//   acq_lock        per-thread requested lock ID
//   acq_done        per-thread one-cycle grant pulse
//   rel_req         per-thread release pulse
//   held            per-thread lock ownership
//   request_lock    acquire request to the table
//   lock_requested  lock ID of the acquire request
//   lock_granted    table's combinational reply to request_lock
//   release_lock    release request to the table
//   lock_released   lock ID being released
//   deny_count      saturating count of denied acquires
// -----------------------------------------------------------------------------
module lock_request_arbiter
  import lock_request_arbiter_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int LOCK_WIDTH  = lock_request_arbiter_pkg::LOCK_WIDTH,
  parameter int RETRY_DELAY = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_THREADS-1:0]                acq_req,
  input  logic [NUM_THREADS-1:0][LOCK_WIDTH-1:0] acq_lock,
  output logic [NUM_THREADS-1:0]                acq_done,
  input  logic [NUM_THREADS-1:0]                rel_req,
  output logic [NUM_THREADS-1:0]                held,
  output logic                                  request_lock,
  output logic [LOCK_WIDTH-1:0]                 lock_requested,
  input  logic                                  lock_granted,
  output logic                                  release_lock,
  output logic [LOCK_WIDTH-1:0]                 lock_released,
  output logic [DENY_CNT_W-1:0]                 deny_count
);

  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [NUM_THREADS-1:0]                 pend;
  logic [NUM_THREADS-1:0]                 rel_pend;
  logic [NUM_THREADS-1:0]                 eligible;
  logic [NUM_THREADS-1:0]                 acq_sel;
  logic [NUM_THREADS-1:0]                 rel_sel;
  logic [NUM_THREADS-1:0][LOCK_WIDTH-1:0] held_id;

  // rr_ptr is the thread with highest acquire priority this cycle.
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] acq_win;
  logic [PTR_W-1:0] rel_win;
  logic [PTR_W-1:0] win_hi;
  logic [PTR_W-1:0] win_lo;
  logic             found_hi;
  logic             found_lo;
  logic             rel_any;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thread
    lock_thread_fsm #(
      .LOCK_W      (LOCK_WIDTH),
      .RETRY_DELAY (RETRY_DELAY)
    ) u_thread (
      .clk      (clk),
      .rst      (rst),
      .acq_req  (acq_req[g]),
      .acq_lock (acq_lock[g]),
      .rel_req  (rel_req[g]),
      .acq_sel  (acq_sel[g]),
      .granted  (lock_granted),
      .rel_sel  (rel_sel[g]),
      .pend     (pend[g]),
      .rel_pend (rel_pend[g]),
      .held     (held[g]),
      .acq_done (acq_done[g]),
      .held_id  (held_id[g])
    );
  end

  // Release: lowest-index REL_PEND thread wins.
  always_comb begin
    rel_any = 1'b0;
    rel_win = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (rel_pend[i]) begin
        rel_any = 1'b1;
        rel_win = PTR_W'(i);
      end
    end
  end

  assign release_lock  = rel_any;
  assign lock_released = rel_any ? held_id[rel_win] : '0;

  // Conflict mask: the table still shows the lock being released as taken
  // this cycle, so requesting it now would only earn a spurious deny.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++)
      eligible[i] = pend[i] && !(rel_any && (held_id[i] == lock_released));
  end

  // Round-robin: lowest eligible index at or above rr_ptr, else wrap to the
  // lowest eligible index below it. Scanning downward leaves the lowest hit.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (PTR_W'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          win_hi   = PTR_W'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = PTR_W'(i);
        end
      end
    end
    acq_win = found_hi ? win_hi : win_lo;
  end

  assign request_lock   = |eligible;
  assign lock_requested = request_lock ? held_id[acq_win] : '0;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      acq_sel[i] = request_lock && (acq_win == PTR_W'(i));
      rel_sel[i] = rel_any && (rel_win == PTR_W'(i));
    end
  end

  // Pointer moves past the winner only when a request is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      deny_count <= '0;
    end else begin
      if (request_lock)
        rr_ptr <= (acq_win == PTR_W'(NUM_THREADS - 1)) ? '0 : acq_win + PTR_W'(1);
      if (request_lock && !lock_granted)
        deny_count <= sat_inc(deny_count);
    end
  end

endmodule
